// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bundle for imem_loader.
// Signal names keep the loader's point of view (_i into it, _o out of it).
interface imem_loader_if #(
    parameter int ADDR_W = 13
);
    logic              start_i;
    logic              byte_valid_i;
    logic [7:0]        byte_i;
    logic              byte_ready_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [31:0]       wr_data_o;
    logic              core_hold_o;
    logic              done_o;
    logic              err_o;

    modport slave (
        input  start_i, byte_valid_i, byte_i,
        output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, core_hold_o, done_o, err_o
    );

    modport master (
        output start_i, byte_valid_i, byte_i,
        input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, core_hold_o, done_o, err_o
    );
endinterface

// File: rtl/imem_loader.sv
// Loads instruction memory from a LE byte stream (4-byte word count, then words).
// Write strobe one cycle after a word's 4th byte; byte_ready_o high in LEN/DATA, stalls of any length OK.
module imem_loader #(
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = 13
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_byte_cnt;
    logic [ADDR_W:0]   r_word_cnt;
    logic [31:0]       r_len;
    logic [23:0]       r_asm;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;

    logic              w_ready;
    logic              w_accept;
    logic              w_last_byte;
    logic              w_start;
    logic [31:0]       w_len_full;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_word_cnt_nxt;
    logic              w_last_word;

    assign w_ready        = (r_state == S_LEN) || (r_state == S_DATA);
    assign w_accept       = bus.byte_valid_i && w_ready;
    assign w_last_byte    = w_accept && (r_byte_cnt == 2'd3);
    assign w_start        = bus.start_i && ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_len_full     = {bus.byte_i, r_len[23:0]};
    assign w_word         = {bus.byte_i, r_asm};
    assign w_word_cnt_nxt = r_word_cnt + 1'b1;
    // Length was bounded to DEPTH in LEN, so a full 32-bit compare is exact.
    assign w_last_word    = ({{(31-ADDR_W){1'b0}}, w_word_cnt_nxt} == r_len);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                if (w_last_byte) begin
                    if (w_len_full == 32'd0)              w_state_nxt = S_DONE;
                    else if (w_len_full > 32'(DEPTH))     w_state_nxt = S_ERR;
                    else                                  w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last_byte && w_last_word) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (w_start) w_state_nxt = S_LEN;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_len      <= '0;
            r_asm      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start) begin
                r_byte_cnt <= '0;
                r_word_cnt <= '0;
                r_len      <= '0;
            end
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_state == S_LEN) begin
                    r_len[{r_byte_cnt, 3'b000} +: 8] <= bus.byte_i;
                end else begin
                    case (r_byte_cnt)
                        2'd0: r_asm[7:0]   <= bus.byte_i;
                        2'd1: r_asm[15:8]  <= bus.byte_i;
                        2'd2: r_asm[23:16] <= bus.byte_i;
                        default: begin
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= r_word_cnt[ADDR_W-1:0];
                            r_wr_data  <= w_word;
                            r_word_cnt <= w_word_cnt_nxt;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.byte_ready_o = w_ready;
    assign bus.wr_en_o      = r_wr_en;
    assign bus.wr_addr_o    = r_wr_addr;
    assign bus.wr_data_o    = r_wr_data;
    assign bus.core_hold_o  = (r_state != S_IDLE);
    assign bus.done_o       = (r_state == S_DONE);
    assign bus.err_o        = (r_state == S_ERR);
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: vector table of loads plus hand sequences, writes scored
// against an expected-write queue built from the word list.
module tb_imem_loader;
    localparam int DEPTH  = 8192;
    localparam int ADDR_W = 13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] hdr;
        int          nsend;
        int          gap;
        bit          chk_rdy;
        int          exp_writes;
        bit          exp_err;
    } vec_t;

    wr_t         exp_q[$];
    logic [31:0] payload[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_wr     = 0;
    int          n_done   = 0;
    int          last_addr = -1;
    logic        exp_wr_on_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.wr_en_o === 1'b1) begin
                n_wr++;
                last_addr = int'(bus.wr_addr_o);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wr actual addr=%0h data=%0h required=no write",
                             bus.wr_addr_o, bus.wr_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(bus.wr_addr_o), 64'(e.addr));
                    chk("wr_data", 64'(bus.wr_data_o), 64'(e.data));
                end
            end
            if (bus.done_o === 1'b1) begin
                n_done++;
                chk("done_with_wr", 64'(bus.wr_en_o), 64'(exp_wr_on_done));
                chk("done_hold", 64'(bus.core_hold_o), 64'd1);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pulse();
        bus.start_i = 1'b1;
        cyc(1);
        bus.start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_rdy);
        bit acc;
        int tries;
        bus.byte_valid_i = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (chk_rdy) chk("stall_rdy", 64'(bus.byte_ready_o), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = b;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            @(negedge clk);
            acc = bus.byte_ready_o;
            @(posedge clk);
            #1;
            tries++;
        end
        bus.byte_valid_i = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_accept actual=timeout required=accepted byte=%0h", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit chk_rdy);
        logic [31:0] v;
        v = w;
        for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], gap, chk_rdy);
    endtask

    // Start, send header and nsend words; expected writes come from the rules:
    // a legal nonzero length writes word i to address i.
    task automatic load(input logic [31:0] hdr, input int nsend, input int gap, input bit chk_rdy);
        logic [31:0] w;
        bit          legal;
        legal = (hdr != 32'd0) && (hdr <= 32'(DEPTH));
        exp_wr_on_done = (hdr != 32'd0);
        start_pulse();
        chk("start_err_clr", 64'(bus.err_o), 64'd0);
        chk("start_hold", 64'(bus.core_hold_o), 64'd1);
        send_word(hdr, gap, chk_rdy);
        for (int i = 0; i < nsend; i++) begin
            w = (i < payload.size()) ? payload[i] : $urandom;
            if (legal && (32'(i) < hdr)) exp_q.push_back('{addr: 32'(i), data: w});
            send_word(w, gap, chk_rdy);
        end
    endtask

    task automatic finish_load(input bit exp_err, input int exp_writes, input int wr0, input int done0);
        chk("end_done", 64'(bus.done_o), 64'(!exp_err));
        chk("end_err", 64'(bus.err_o), 64'(exp_err));
        chk("end_rdy", 64'(bus.byte_ready_o), 64'd0);
        cyc(1);
        chk("after_hold", 64'(bus.core_hold_o), 64'(exp_err));
        chk("after_done", 64'(bus.done_o), 64'd0);
        cyc(2);
        chk("n_writes", 64'(n_wr - wr0), 64'(exp_writes));
        chk("n_done", 64'(n_done - done0), 64'(exp_err ? 0 : 1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   wr0, done0;
        bus.start_i      = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;
        fork
            monitor();
        join_none

        cyc(3);
        @(negedge clk);
        chk("rst_ctrl", 64'({bus.byte_ready_o, bus.wr_en_o, bus.core_hold_o, bus.done_o, bus.err_o}), 64'd0);
        chk("rst_addr", 64'(bus.wr_addr_o), 64'd0);
        chk("rst_data", 64'(bus.wr_data_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(2);
        chk("idle_hold", 64'(bus.core_hold_o), 64'd0);

        // Basic two-word load with the fixed payload.
        payload = '{32'h0000_0013, 32'h0010_0093};
        wr0 = n_wr; done0 = n_done;
        load(32'd2, 2, 0, 1'b0);
        finish_load(1'b0, 2, wr0, done0);
        // Same payload, 3-cycle stalls between bytes.
        wr0 = n_wr; done0 = n_done;
        load(32'd2, 2, 3, 1'b1);
        finish_load(1'b0, 2, wr0, done0);
        payload.delete();

        vecs.push_back('{hdr: 32'd1,          nsend: 1, gap: 0, chk_rdy: 1'b0, exp_writes: 1, exp_err: 1'b0});
        vecs.push_back('{hdr: 32'd3,          nsend: 3, gap: 2, chk_rdy: 1'b1, exp_writes: 3, exp_err: 1'b0});
        vecs.push_back('{hdr: 32'd0,          nsend: 0, gap: 0, chk_rdy: 1'b0, exp_writes: 0, exp_err: 1'b0});
        vecs.push_back('{hdr: 32'd8193,       nsend: 0, gap: 0, chk_rdy: 1'b0, exp_writes: 0, exp_err: 1'b1});
        vecs.push_back('{hdr: 32'd1,          nsend: 1, gap: 1, chk_rdy: 1'b1, exp_writes: 1, exp_err: 1'b0});
        vecs.push_back('{hdr: 32'h0001_0002,  nsend: 0, gap: 0, chk_rdy: 1'b0, exp_writes: 0, exp_err: 1'b1});
        vecs.push_back('{hdr: 32'h8000_0000,  nsend: 0, gap: 1, chk_rdy: 1'b0, exp_writes: 0, exp_err: 1'b1});
        vecs.push_back('{hdr: 32'd4,          nsend: 4, gap: 0, chk_rdy: 1'b0, exp_writes: 4, exp_err: 1'b0});
        for (int r = 0; r < 6; r++) begin
            v.hdr        = 32'($urandom_range(1, 6));
            v.nsend      = int'(v.hdr);
            v.gap        = int'($urandom_range(0, 2));
            v.chk_rdy    = 1'b1;
            v.exp_writes = int'(v.hdr);
            v.exp_err    = 1'b0;
            vecs.push_back(v);
        end

        foreach (vecs[i]) begin
            wr0 = n_wr; done0 = n_done;
            load(vecs[i].hdr, vecs[i].nsend, vecs[i].gap, vecs[i].chk_rdy);
            finish_load(vecs[i].exp_err, vecs[i].exp_writes, wr0, done0);
        end

        // Reset after two of three words; those writes stay, the load is dropped.
        wr0 = n_wr;
        exp_wr_on_done = 1'b1;
        start_pulse();
        send_word(32'd3, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] w;
            w = $urandom;
            exp_q.push_back('{addr: 32'(i), data: w});
            send_word(w, 0, 1'b0);
        end
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_ctrl", 64'({bus.byte_ready_o, bus.wr_en_o, bus.core_hold_o, bus.done_o, bus.err_o}), 64'd0);
        chk("midrst_addr", 64'(bus.wr_addr_o), 64'd0);
        chk("midrst_data", 64'(bus.wr_data_o), 64'd0);
        rst_n = 1'b1;
        cyc(1);
        chk("midrst_writes", 64'(n_wr - wr0), 64'd2);
        wr0 = n_wr; done0 = n_done;
        load(32'd1, 1, 0, 1'b0);
        finish_load(1'b0, 1, wr0, done0);
        chk("restart_addr", 64'(last_addr), 64'd0);

        // Full depth, bytes back to back.
        wr0 = n_wr; done0 = n_done;
        load(32'(DEPTH), DEPTH, 0, 1'b0);
        finish_load(1'b0, DEPTH, wr0, done0);
        chk("full_last_addr", 64'(last_addr), 64'(DEPTH - 1));
        chk("full_err", 64'(bus.err_o), 64'd0);

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
